// File: rtl/conv_enc_frame_ctrl_if.sv
// Bundle of control, source, encoder and sink signals around the
// convolutional-encoder frame sequencer.
interface conv_enc_frame_ctrl_if #(
   parameter int LEN_W = 7
);
   logic             start;
   logic [LEN_W-1:0] frame_len;
   logic             busy;
   logic             in_valid;
   logic             in_bit;
   logic             in_ready;
   logic             enc_clr;
   logic             enc_en;
   logic             enc_bit;
   logic [1:0]       enc_out;
   logic             out_valid;
   logic [1:0]       out_sym;
   logic             out_ready;
   logic             done;

   modport master (
      input  start, frame_len, in_valid, in_bit, enc_out, out_ready,
      output busy, in_ready, enc_clr, enc_en, enc_bit, out_valid, out_sym, done
   );

   modport slave (
      output start, frame_len, in_valid, in_bit, enc_out, out_ready,
      input  busy, in_ready, enc_clr, enc_en, enc_bit, out_valid, out_sym, done
   );
endinterface

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for a rate-1/2 K=3 convolutional encoder: clears the encoder,
// steps it per data bit plus zero tail bits, and buffers symbols in a 2-deep FIFO.
module conv_enc_frame_ctrl #(
   parameter int LEN_W = 7,
   parameter int TAIL  = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   conv_enc_frame_ctrl_if.master bus
);

   localparam int TC_W = (TAIL < 2) ? 1 : $clog2(TAIL + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_DATA,
      S_TAIL,
      S_DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [TC_W-1:0]  tail_cnt_q, tail_cnt_d;
   logic             busy_q, busy_d;
   logic             enc_clr_q, enc_clr_d;
   logic             done_q, done_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       occ_q, occ_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       mem_q [2];

   logic             push;
   logic             pop;
   logic             credit_ok;
   logic             data_hs;
   logic             step;
   logic [2:0]       pending;

   // A step is only issued if its symbol is guaranteed a FIFO slot when it lands.
   always_comb begin
      pop       = (occ_q != 2'd0) && bus.out_ready;
      push      = inflight_q;
      pending   = {1'b0, occ_q} + {2'b00, inflight_q};
      credit_ok = pending < (3'd2 + {2'b00, pop});
      data_hs   = (state_q == S_DATA) && bus.in_valid && credit_ok;
      step      = data_hs || ((state_q == S_TAIL) && credit_ok);
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      tail_cnt_d  = tail_cnt_q;
      busy_d      = busy_q;
      enc_clr_d   = 1'b0;
      done_d      = 1'b0;
      inflight_d  = step;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               remaining_d = bus.frame_len;
               busy_d      = 1'b1;
               enc_clr_d   = 1'b1;
               state_d     = S_CLEAR;
            end
         end
         S_CLEAR: begin
            tail_cnt_d = TC_W'(TAIL);
            state_d    = (remaining_q == '0) ? S_TAIL : S_DATA;
         end
         S_DATA: begin
            if (data_hs) begin
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = S_TAIL;
               end
            end
         end
         S_TAIL: begin
            if (step) begin
               tail_cnt_d = tail_cnt_q - TC_W'(1);
               if (tail_cnt_q == TC_W'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!inflight_q && (occ_q == 2'd0)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         tail_cnt_q  <= '0;
         busy_q      <= 1'b0;
         enc_clr_q   <= 1'b0;
         done_q      <= 1'b0;
         inflight_q  <= 1'b0;
         occ_q       <= 2'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         tail_cnt_q  <= tail_cnt_d;
         busy_q      <= busy_d;
         enc_clr_q   <= enc_clr_d;
         done_q      <= done_d;
         inflight_q  <= inflight_d;
         occ_q       <= occ_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // The encoder output is valid exactly one cycle after its step, so capture on inflight.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            mem_q[gi] <= 2'b00;
         end else if (push && (wr_ptr_q == 1'(gi))) begin
            mem_q[gi] <= bus.enc_out;
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.in_ready  = (state_q == S_DATA) && credit_ok;
   assign bus.enc_clr   = enc_clr_q;
   assign bus.enc_en    = step;
   assign bus.enc_bit   = data_hs && bus.in_bit;
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.out_sym   = mem_q[rd_ptr_q];
   assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Randomized scoreboard bench for conv_enc_frame_ctrl with a behavioural
// encoder attached and a sequence-level convolution reference model.
module tb_conv_enc_frame_ctrl;
   localparam int LEN_W = 7;
   localparam int TAIL  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_enc_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

   conv_enc_frame_ctrl #(.LEN_W(LEN_W), .TAIL(TAIL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [1:0] exp_q [$];
   bit cur_bits [$];

   int sym_cnt, enc_cnt, clr_cnt, done_cnt, max_out;
   bit in_ready_seen, gap_active, held_valid;
   logic [1:0] held_sym;
   int rdy_mode = 0;
   int rdy_pct = 100;

   task automatic chk(input string name, input int act, input int exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // External encoder: registered output, cleared by enc_clr.
   logic [1:0] enc_st, enc_o;
   always @(posedge clk) begin
      if (!rst_n) begin
         enc_st <= 2'b00;
         enc_o  <= 2'b00;
      end else if (bus.enc_clr) begin
         enc_st <= 2'b00;
         enc_o  <= 2'b00;
      end else if (bus.enc_en) begin
         enc_o  <= {bus.enc_bit ^ enc_st[1] ^ enc_st[0], bus.enc_bit ^ enc_st[0]};
         enc_st <= {bus.enc_bit, enc_st[1]};
      end
   end
   assign bus.enc_out = enc_o;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = ~bus.out_ready;
         default: bus.out_ready = ($urandom_range(1, 100) <= rdy_pct);
      endcase
   end

   // Reference: each symbol is the convolution of the zero-padded bit sequence.
   task automatic push_expected(input int len);
      bit x [$];
      logic [1:0] s;
      bit b, p1, p2;
      x = cur_bits;
      for (int t = 0; t < TAIL; t++) x.push_back(1'b0);
      for (int n = 0; n < len + TAIL; n++) begin
         b  = x[n];
         p1 = (n >= 1) ? x[n-1] : 1'b0;
         p2 = (n >= 2) ? x[n-2] : 1'b0;
         s[1] = b ^ p1 ^ p2;
         s[0] = b ^ p2;
         exp_q.push_back(s);
      end
   endtask

   always @(negedge clk) begin
      logic [1:0] e;
      if (!rst_n) begin
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_sym", int'(bus.out_sym), int'(held_sym));
         end
         held_valid = bus.out_valid && !bus.out_ready;
         held_sym   = bus.out_sym;
         if (bus.out_valid && bus.out_ready) begin
            sym_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_sym", int'(bus.out_sym), -1);
            end else begin
               e = exp_q.pop_front();
               chk("sym", int'(bus.out_sym), int'(e));
            end
         end
         if (bus.enc_en)   enc_cnt++;
         if (bus.enc_clr)  clr_cnt++;
         if (bus.done)     done_cnt++;
         if (bus.in_ready) in_ready_seen = 1'b1;
         if ((enc_cnt - sym_cnt) > max_out) max_out = enc_cnt - sym_cnt;
         if (gap_active) chk("gap_no_step", int'(bus.enc_en), 0);
      end
   end

   function automatic int out_vec();
      return int'({bus.busy, bus.in_ready, bus.enc_clr, bus.enc_en, bus.enc_bit,
                   bus.out_valid, bus.out_sym, bus.done});
   endfunction

   task automatic run_frame(input int len, input int vpct, input int gap_pos,
                            input int abort_syms, input bit spurious, output bit aborted);
      int idx;
      int budget;
      bit hs;
      bit gap_done;
      aborted = 1'b0;
      sym_cnt = 0; enc_cnt = 0; clr_cnt = 0; done_cnt = 0; max_out = 0;
      in_ready_seen = 1'b0;
      push_expected(len);
      bus.frame_len = LEN_W'(len);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("busy_set", int'(bus.busy), 1);

      idx = 0; budget = 0; gap_done = 1'b0;
      while (idx < len) begin
         if (budget++ > 3000) begin
            chk("feed_timeout", idx, len);
            break;
         end
         if (!gap_done && idx == gap_pos) begin
            gap_done = 1'b1;
            bus.in_valid = 1'b0;
            gap_active = 1'b1;
            repeat (5) begin @(posedge clk); #1; end
            gap_active = 1'b0;
         end
         if ($urandom_range(1, 100) > vpct) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            continue;
         end
         bus.in_valid = 1'b1;
         bus.in_bit   = cur_bits[idx];
         @(negedge clk);
         hs = bus.in_ready;
         @(posedge clk); #1;
         if (hs) idx++;
         if (abort_syms > 0 && sym_cnt >= abort_syms) begin
            aborted = 1'b1;
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      if (aborted) return;

      if (spurious) begin
         bus.frame_len = LEN_W'(9);
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (done_cnt > 0) break;
      end
      chk("done_once", done_cnt, 1);
      chk("busy_after_done", int'(bus.busy), 0);
      chk("sym_count", sym_cnt, len + TAIL);
      chk("step_count", enc_cnt, len + TAIL);
      chk("clr_count", clr_cnt, 1);
      chk("queue_empty", exp_q.size(), 0);
      chk("credit_bound", int'(max_out <= 2), 1);
      if (len == 0) chk("no_in_ready", int'(in_ready_seen), 0);
      exp_q.delete();
   endtask

   task automatic load_fixed6();
      cur_bits.delete();
      cur_bits.push_back(1'b0); cur_bits.push_back(1'b1); cur_bits.push_back(1'b1);
      cur_bits.push_back(1'b1); cur_bits.push_back(1'b0); cur_bits.push_back(1'b0);
   endtask

   task automatic load_random(input int len);
      cur_bits.delete();
      for (int i = 0; i < len; i++) cur_bits.push_back(1'($urandom_range(0, 1)));
   endtask

   initial begin
      bit ab;
      int len;
      bus.start = 1'b0; bus.frame_len = '0; bus.in_valid = 1'b0;
      bus.in_bit = 1'b0; bus.out_ready = 1'b1;
      gap_active = 1'b0; held_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", out_vec(), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fixed 6-bit frame at full rate.
      rdy_mode = 0;
      load_fixed6();
      run_frame(6, 100, -1, 0, 1'b0, ab);

      // Single-bit and empty frames.
      cur_bits.delete(); cur_bits.push_back(1'b1);
      run_frame(1, 100, -1, 0, 1'b0, ab);
      cur_bits.delete();
      run_frame(0, 100, -1, 0, 1'b0, ab);

      // Sink toggling every cycle.
      rdy_mode = 1;
      load_fixed6();
      run_frame(6, 100, -1, 0, 1'b0, ab);

      // Source gap of five cycles mid-frame.
      rdy_mode = 0;
      load_fixed6();
      run_frame(6, 100, 3, 0, 1'b0, ab);

      // Back-to-back frames, one with a start request while busy.
      load_random(10);
      run_frame(10, 100, -1, 0, 1'b1, ab);
      load_random(4);
      run_frame(4, 100, -1, 0, 1'b0, ab);

      // Reset after the third symbol, then the fixed frame again.
      load_fixed6();
      run_frame(6, 100, -1, 3, 1'b0, ab);
      chk("abort_taken", int'(ab), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("reset_mid_outputs", out_vec(), 0);
      chk("no_done_abort", done_cnt, 0);
      exp_q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      load_fixed6();
      run_frame(6, 100, -1, 0, 1'b0, ab);

      // Randomized frames with random backpressure and source stalls.
      rdy_mode = 2;
      for (int f = 0; f < 25; f++) begin
         len = (f == 12) ? 127 : int'($urandom_range(0, 40));
         rdy_pct = int'($urandom_range(30, 100));
         load_random(len);
         run_frame(len, int'($urandom_range(50, 100)), -1, 0, (f % 7) == 3, ab);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
